mem64_port_arbiter: RTL and testbench
=====================================

Name: mem64_port_arbiter

Overview:
- Multi-cycle arbiter that shares the single 64-bit data memory port (Memoria64) between two requesters.
- Requester 0 is the CPU load/store path driven by the control unit. Requester 1 is the debug/program loader.
- Grants are round-robin. The arbiter latches the winner's command, drives the memory for a fixed latency, captures read data and returns a one-cycle done pulse.
- Sits between the requesters and Memoria64, replacing the direct muxPC/muxMem64 hookup on the memory side.

Parameters:
- ADDR_W, 64, address width.
- DATA_W, 64, data width.
- MEM_LAT, 1, memory read latency in cycles from address stable to Dataout valid; legal range 1..15.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset.
- req0  input  1  requester 0 request; held high until done0.
- wr0  input  1  requester 0 operation: 1 = write, 0 = read.
- addr0  input  ADDR_W  requester 0 address.
- wdata0  input  DATA_W  requester 0 write data.
- done0  output  1  one-cycle completion pulse to requester 0.
- req1, wr1, addr1, wdata1, done1: same meaning, for requester 1.
- rdata  output  DATA_W  captured read data; valid during the done pulse and held until the next capture.
- mem_addr  output  ADDR_W  drives Memoria64 raddress and waddress.
- mem_wdata  output  DATA_W  drives Memoria64 Datain.
- mem_wr  output  1  drives Memoria64 Wr.
- mem_rdata  input  DATA_W  from Memoria64 Dataout.
- busy  output  1  high in ACCESS and DONE states.
- last_gnt  output  1  index of the most recently granted requester.

Behaviour:
- Reset (Reset=0 at a rising edge):
  - state=IDLE, done0=done1=0, mem_wr=0, mem_addr=0, mem_wdata=0, rdata=0, busy=0, last_gnt=1, latency counter=0.
  - Reset has priority over every other event. Reset during ACCESS aborts the operation: mem_wr is 0 from the next cycle and no done pulse is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - No request: stay in IDLE; mem_addr/mem_wdata hold their last values.
  - Exactly one req high: grant that requester.
  - Both req high: grant the requester != last_gnt (round-robin). After reset requester 0 wins the first tie.
  - On grant: latch addr, wdata and wr into mem_addr/mem_wdata/op; set last_gnt=winner; counter=0; go to ACCESS.
- ACCESS:
  - mem_addr and mem_wdata are held stable throughout.
  - For a write, mem_wr=1 in the first ACCESS cycle only, then 0.
  - Counter increments each cycle. When counter==MEM_LAT-1: for a read, rdata<=mem_rdata at that edge; go to DONE. A write also stays MEM_LAT cycles, for uniform timing.
- DONE:
  - done of the granted requester =1 for exactly this cycle; the other done stays 0.
  - Always returns to IDLE.
- Latency:
  - req sampled at edge E gives ACCESS for MEM_LAT cycles, then done high in the cycle after ACCESS.
  - MEM_LAT=1: done is visible 2 cycles after the sampling edge.
  - Maximum throughput: one transfer per MEM_LAT+2 cycles.
- Handshake rules:
  - A requester must deassert req at the edge ending its done cycle, unless it issues a new request. A req still high in IDLE is treated as a new request.
  - Changes to addr/wdata/wr after grant are ignored; the latched values are used.
  - Dropping req during ACCESS does not cancel the operation; done still pulses.
- Requests are never dropped. A losing requester keeps req high and is granted in the next IDLE because of round-robin, so its wait is bounded to one transfer.
- mem_wr is never high outside ACCESS.
- rdata is unchanged by writes.

Test Plan:
- Reset, then req0=1, wr0=0, addr0=0x10; memory holds 0xDEADBEEF00000001 at 0x10 (MEM_LAT=1) -> mem_addr=0x10 the next cycle, done0 high 2 cycles after sampling, rdata=0xDEADBEEF00000001, done1 stays 0.
- req1=1, wr1=1, addr1=0x20, wdata1=0x55 -> mem_wr high for exactly 1 cycle with mem_addr=0x20, mem_wdata=0x55; done1 pulses; a subsequent read of 0x20 returns 0x55.
- req0 and req1 both high continuously right after reset -> grants alternate 0,1,0,1; last_gnt toggles; each done lasts 1 cycle; no starvation across 8 transfers.
- Reset asserted during ACCESS of a write (MEM_LAT=3) -> next cycle state=IDLE, mem_wr=0, no done; last_gnt=1; a following tie grants requester 0.
- addr0 changed from 0x10 to 0x30 one cycle after grant -> mem_addr stays 0x10 throughout the transfer.
- MEM_LAT=4, read -> done exactly 5 cycles after sampling edge; busy high for 5 cycles; rdata captured from mem_rdata at the 4th ACCESS edge.

Source files
------------

// File: rtl/mem64_port_arbiter.sv
// mem64_port_arbiter: round-robin sharing of the 64-bit Memoria64 data port between the CPU path and the debug loader
module mem64_port_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              done0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              done1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              last_gnt
);
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  localparam logic [3:0] LAST = 4'(MEM_LAT - 1);
  state_t state;
  logic [3:0] latCnt;
  logic opWr;
  logic winner;
  // a tie goes to whichever requester was not served most recently
  assign winner = (req0 && req1) ? ~last_gnt : req1;
  // grant, hold the latched command for MEM_LAT cycles, then pulse done for one cycle
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      done0 <= 1'b0;
      done1 <= 1'b0;
      mem_wr <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata <= '0;
      busy <= 1'b0;
      last_gnt <= 1'b1;
      latCnt <= '0;
      opWr <= 1'b0;
    end else begin
      done0 <= 1'b0;
      done1 <= 1'b0;
      mem_wr <= 1'b0;
      case (state)
        IDLE: if (req0 || req1) begin
          state <= ACCESS;
          busy <= 1'b1;
          last_gnt <= winner;
          latCnt <= '0;
          opWr <= winner ? wr1 : wr0;
          mem_wr <= winner ? wr1 : wr0;
          mem_addr <= winner ? addr1 : addr0;
          mem_wdata <= winner ? wdata1 : wdata0;
        end
        ACCESS: if (latCnt == LAST) begin
          state <= DONE;
          rdata <= opWr ? rdata : mem_rdata;
          done0 <= ~last_gnt;
          done1 <= last_gnt;
        end else latCnt <= latCnt + 4'd1;
        DONE: begin
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem64_port_arbiter.sv
// tb_mem64_port_arbiter: checks the arbiter at MEM_LAT 1, 3 and 4 against a transfer-level model
module tb_mem64_port_arbiter;
  logic clk = 1'b0;
  int nTests = 0;
  int nFail = 0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
    logic reset, req0, wr0, req1, wr1, done0, done1, mem_wr, busy, last_gnt;
    logic [63:0] addr0, wdata0, addr1, wdata1, rdata, mem_addr, mem_wdata, mem_rdata;
    logic [63:0] mem [16];
    logic [63:0] prevAddr = '0;
    int age = 0;
    bit fin = 1'b0;
    int rem = 0;
    logic lg, mOp;
    logic [63:0] mAddr, mWd, eRd;
    int cyc, busyN, wrN;
    logic addrBad, gotDone, otherDone;
    logic [63:0] wAddr, wData;

    mem64_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(LAT)) dut (
      .Clk(clk), .Reset(reset),
      .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0), .done0(done0),
      .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1), .done1(done1),
      .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr),
      .mem_rdata(mem_rdata), .busy(busy), .last_gnt(last_gnt)
    );

    // memory: data becomes valid only after the address has been stable for LAT cycles
    assign mem_rdata = ((((mem_addr !== prevAddr) ? 0 : age) >= LAT - 1)) ? mem[mem_addr[7:4]] : ~mem[mem_addr[7:4]];
    always @(posedge clk) begin
      age <= (mem_addr !== prevAddr) ? 1 : age + 1;
      prevAddr <= mem_addr;
    end

    // transfer-level model: rem counts the cycles left in the current transfer
    task automatic step();
      if (rem == LAT + 1 && mOp) mem[mAddr[7:4]] <= mWd;
      if (!reset) begin
        rem = 0; lg = 1'b1; mOp = 1'b0; mAddr = '0; mWd = '0; eRd = '0;
      end else if (rem > 0) begin
        if (rem == 2 && !mOp) eRd = mem[mAddr[7:4]];
        rem--;
      end else if (req0 || req1) begin
        lg = (req0 && req1) ? !lg : req1;
        mOp = lg ? wr1 : wr0;
        mAddr = lg ? addr1 : addr0;
        mWd = lg ? wdata1 : wdata0;
        rem = LAT + 1;
      end
    endtask

    task automatic compare();
      logic [4:0] act, exp;
      act = {busy, mem_wr, done0, done1, last_gnt};
      exp = {rem > 0, mOp && rem == LAT + 1, rem == 1 && !lg, rem == 1 && lg, lg};
      nTests++;
      if (act !== exp || mem_addr !== mAddr || mem_wdata !== mWd || rdata !== eRd) begin
        nFail++;
        $display("FAIL [lat%0d] model_cycle t=%0t busy/wr/d0/d1/gnt got %b want %b addr got %h want %h wdata got %h want %h rdata got %h want %h",
                 LAT, $time, act, exp, mem_addr, mAddr, mem_wdata, mWd, rdata, eRd);
      end
    endtask

    task automatic tick();
      @(posedge clk);
      step();
      @(negedge clk);
      compare();
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nTests++;
      if (act !== exp) begin
        nFail++;
        $display("FAIL [lat%0d] %s: got %h, want %h", LAT, name, act, exp);
      end
    endtask

    task automatic waitDone(input logic who, input logic [63:0] expAddr, input logic [63:0] lateAddr);
      cyc = 0; busyN = 0; wrN = 0; addrBad = 1'b0; otherDone = 1'b0; gotDone = 1'b0;
      do begin
        tick();
        cyc++;
        busyN += int'(busy);
        if (mem_wr) begin wrN++; wAddr = mem_addr; wData = mem_wdata; end
        if (mem_addr !== expAddr) addrBad = 1'b1;
        if (cyc == 1) begin if (who) addr1 = lateAddr; else addr0 = lateAddr; end
        gotDone = who ? done1 : done0;
        if (gotDone) otherDone = who ? done0 : done1;
      end while (!gotDone && cyc < 40);
      if (who) req1 = 1'b0; else req0 = 1'b0;
      tick();
    endtask

    function automatic logic nextReq(input logic done, input logic cur);
      return done ? ($urandom_range(0, 3) == 0) : cur ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 2) == 0);
    endfunction

    initial begin
      for (int i = 0; i < 16; i++) mem[i] = 64'hDEADBEEF00000000 | 64'(i);
      reset = 1'b0; req0 = 1'b0; wr0 = 1'b0; req1 = 1'b0; wr1 = 1'b0;
      addr0 = '0; wdata0 = '0; addr1 = '0; wdata1 = '0;
      tick(); tick();
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_last_gnt", 64'(last_gnt), 64'd1);
      chk("reset_mem_addr", mem_addr, 64'd0);
      chk("reset_rdata", rdata, 64'd0);
      chk("reset_done_wr", 64'({done0, done1, mem_wr}), 64'd0);
      reset = 1'b1;
      req0 = 1'b1; wr0 = 1'b0; addr0 = 64'h10;
      waitDone(1'b0, 64'h10, 64'h30);
      chk("read_latency", 64'(cyc), 64'(LAT + 1));
      chk("read_busy_cycles", 64'(busyN), 64'(LAT + 1));
      chk("read_no_write", 64'(wrN), 64'd0);
      chk("read_addr_held", 64'(addrBad), 64'd0);
      chk("read_rdata", rdata, 64'hDEADBEEF00000001);
      chk("read_done1_quiet", 64'(otherDone), 64'd0);
      req1 = 1'b1; wr1 = 1'b1; addr1 = 64'h20; wdata1 = 64'h55;
      waitDone(1'b1, 64'h20, 64'h20);
      chk("write_latency", 64'(cyc), 64'(LAT + 1));
      chk("write_wr_cycles", 64'(wrN), 64'd1);
      chk("write_addr", wAddr, 64'h20);
      chk("write_data", wData, 64'h55);
      chk("write_keeps_rdata", rdata, 64'hDEADBEEF00000001);
      chk("write_last_gnt", 64'(last_gnt), 64'd1);
      req0 = 1'b1; wr0 = 1'b0; addr0 = 64'h20;
      waitDone(1'b0, 64'h20, 64'h20);
      chk("readback_latency", 64'(cyc), 64'(LAT + 1));
      chk("readback_rdata", rdata, 64'h55);
      reset = 1'b0;
      tick();
      reset = 1'b1; req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0; addr0 = 64'h40; addr1 = 64'h50;
      for (int n = 0; n < 8; n++) begin
        cyc = 0;
        do begin tick(); cyc++; end while (!(done0 || done1) && cyc < 40);
        chk("tie_latency", 64'(cyc), 64'(LAT + 1));
        chk("tie_winner", 64'({done1, done0}), (n % 2) ? 64'd2 : 64'd1);
        chk("tie_last_gnt", 64'(last_gnt), 64'(n % 2));
        tick();
        chk("tie_done_width", 64'({done1, done0}), 64'd0);
      end
      req0 = 1'b0; req1 = 1'b0;
      tick();
      req0 = 1'b1; wr0 = 1'b1; addr0 = 64'h40; wdata0 = 64'h99;
      tick();
      chk("abort_wr_started", 64'(mem_wr), 64'd1);
      reset = 1'b0; req0 = 1'b0;
      tick();
      chk("abort_mem_wr", 64'(mem_wr), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_no_done", 64'({done0, done1}), 64'd0);
      chk("abort_last_gnt", 64'(last_gnt), 64'd1);
      reset = 1'b1; req0 = 1'b1; req1 = 1'b1; wr0 = 1'b0; wr1 = 1'b0;
      cyc = 0;
      do begin tick(); cyc++; end while (!(done0 || done1) && cyc < 40);
      chk("abort_then_tie", 64'({done1, done0}), 64'd1);
      req0 = 1'b0; req1 = 1'b0;
      tick();
      for (int c = 0; c < 3000; c++) begin
        tick();
        reset = $urandom_range(0, 499) != 0;
        req0 = nextReq(done0, req0);
        req1 = nextReq(done1, req1);
        if ($urandom_range(0, 2) == 0) begin
          wr0 = 1'($urandom); addr0 = {$urandom, $urandom}; wdata0 = {$urandom, $urandom};
        end
        if ($urandom_range(0, 2) == 0) begin
          wr1 = 1'($urandom); addr1 = {$urandom, $urandom}; wdata1 = {$urandom, $urandom};
        end
      end
      fin = 1'b1;
    end
  end

  initial begin
    int waited = 0;
    while (!(inst[0].fin && inst[1].fin && inst[2].fin) && waited < 50000) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50000) begin
      nTests++;
      nFail++;
      $display("FAIL run_timeout: got %0d cycles, want under 50000", waited);
    end
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
